// File: rtl/lsu_nbload_sched.sv
// lsu_nbload_sched: non-blocking load tag tracker with round-robin writeback.
// Optional zero-latency return bypass: define LSU_NBLOAD_WB_BYPASS_EN.
module lsu_nbload_sched #(
   parameter int NUM_TAGS = 4,
   parameter int TAG_W    = $clog2(NUM_TAGS)
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             alloc_req,
   input  logic [4:0]       alloc_rd,
   output logic             alloc_gnt,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             ret_valid,
   input  logic [TAG_W-1:0] ret_tag,
   input  logic [31:0]      ret_data,
   input  logic             ret_err,
   input  logic             flush,
   input  logic [4:0]       cam_rs1,
   input  logic [4:0]       cam_rs2,
   output logic             cam_hit1,
   output logic             cam_hit2,
   input  logic             wb_ready,
   output logic             wb_valid,
   output logic [TAG_W-1:0] wb_tag,
   output logic [4:0]       wb_rd,
   output logic [31:0]      wb_data,
   output logic             wb_err,
   output logic             full,
   output logic             empty,
   output logic             ret_unexp
);

   localparam int CNT_W = $clog2(NUM_TAGS + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DISC = 2'd2,
      ST_RDY  = 2'd3
   } st_e;

   st_e                 st_q   [NUM_TAGS];
   st_e                 st_d   [NUM_TAGS];
   logic [4:0]          rd_q   [NUM_TAGS];
   logic [4:0]          rd_d   [NUM_TAGS];
   logic [31:0]         data_q [NUM_TAGS];
   logic [31:0]         data_d [NUM_TAGS];
   logic [NUM_TAGS-1:0] wb_q, wb_d;
   logic [NUM_TAGS-1:0] err_q, err_d;
   logic [TAG_W-1:0]    rr_q, rr_d;
   logic                hold_q, hold_d;
   logic [TAG_W-1:0]    hold_idx_q, hold_idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [NUM_TAGS-1:0] is_idle, is_pend, is_disc, is_rdy;
   logic [NUM_TAGS-1:0] elig, live;
   logic                have_idle;
   logic [TAG_W-1:0]    free_idx;
   logic                alloc_fire;
   logic                ret_live;
   logic                arb_any;
   logic [TAG_W-1:0]    arb_idx;
   logic                wb_fire;
   logic                byp;

   // Decode per-entry state into flat vectors.
   always_comb begin
      is_idle = '0;
      is_pend = '0;
      is_disc = '0;
      is_rdy  = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         is_idle[i] = (st_q[i] == ST_IDLE);
         is_pend[i] = (st_q[i] == ST_PEND);
         is_disc[i] = (st_q[i] == ST_DISC);
         is_rdy[i]  = (st_q[i] == ST_RDY);
      end
      elig = is_rdy & wb_q;
      live = (is_pend | is_rdy) & wb_q;
   end

   // Lowest-index idle entry from registered state only.
   always_comb begin
      have_idle = 1'b0;
      free_idx  = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (is_idle[i]) begin
            have_idle = 1'b1;
            free_idx  = TAG_W'(i);
         end
      end
   end

   assign full       = (cnt_q == CNT_W'(NUM_TAGS));
   assign empty      = (cnt_q == '0);
   assign alloc_fire = alloc_req & ~full & have_idle;
   assign ret_live   = ret_valid & (is_pend[ret_tag] | is_disc[ret_tag]);

   // Round-robin pick among eligible entries; a stalled grant stays locked.
   always_comb begin : arb_c
      int j;
      arb_any = 1'b0;
      arb_idx = rr_q;
      for (int k = NUM_TAGS - 1; k >= 0; k--) begin
         j = (int'(rr_q) + k) % NUM_TAGS;
         if (elig[j]) begin
            arb_any = 1'b1;
            arb_idx = TAG_W'(j);
         end
      end
      if (hold_q && elig[hold_idx_q]) begin
         arb_any = 1'b1;
         arb_idx = hold_idx_q;
      end
   end

   assign wb_fire = arb_any & wb_ready;

`ifdef LSU_NBLOAD_WB_BYPASS_EN
   assign byp = ~arb_any & wb_ready & ret_valid
              & is_pend[ret_tag] & wb_q[ret_tag];
`else
   assign byp = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            st_q[i]   <= ST_IDLE;
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
         wb_q       <= '0;
         err_q      <= '0;
         rr_q       <= '0;
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
         cnt_q      <= '0;
      end else begin
         st_q       <= st_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         wb_q       <= wb_d;
         err_q      <= err_d;
         rr_q       <= rr_d;
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next-state: per-entry transitions, supersede, pointer and occupancy.
   always_comb begin
      st_d   = st_q;
      rd_d   = rd_q;
      data_d = data_q;
      wb_d   = wb_q;
      err_d  = err_q;
      for (int i = 0; i < NUM_TAGS; i++) begin
         unique case (st_q[i])
            ST_IDLE: begin
               if (alloc_fire && free_idx == TAG_W'(i)) begin
                  st_d[i] = ST_PEND;
                  rd_d[i] = alloc_rd;
                  wb_d[i] = (alloc_rd != 5'd0);
               end
            end
            ST_PEND: begin
               if (ret_live && ret_tag == TAG_W'(i)) begin
                  if (byp) begin
                     st_d[i] = ST_IDLE;
                  end else begin
                     st_d[i]   = ST_RDY;
                     data_d[i] = ret_data;
                     err_d[i]  = ret_err;
                  end
               end else if (flush) begin
                  st_d[i] = ST_DISC;
               end
               if (alloc_fire && rd_q[i] == alloc_rd) begin
                  wb_d[i] = 1'b0;
               end
            end
            ST_DISC: begin
               if (ret_live && ret_tag == TAG_W'(i)) begin
                  st_d[i] = ST_IDLE;
               end
            end
            ST_RDY: begin
               if (!wb_q[i] || (wb_fire && arb_idx == TAG_W'(i))) begin
                  st_d[i] = ST_IDLE;
               end
               if (alloc_fire && rd_q[i] == alloc_rd) begin
                  wb_d[i] = 1'b0;
               end
            end
            default: ;
         endcase
      end

      rr_d = rr_q;
      if (wb_fire) begin
         rr_d = TAG_W'((int'(arb_idx) + 1) % NUM_TAGS);
      end
      hold_d     = arb_any & ~wb_ready;
      hold_idx_d = arb_idx;

      cnt_d = '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (st_d[i] != ST_IDLE) begin
            cnt_d = cnt_d + CNT_W'(1);
         end
      end
   end

   // Outputs: grant, writeback mux, RAW cam, unexpected return.
   always_comb begin
      alloc_gnt = alloc_fire;
      alloc_tag = free_idx;
      ret_unexp = ret_valid & ~ret_live;
      wb_valid  = 1'b0;
      wb_tag    = '0;
      wb_rd     = '0;
      wb_data   = '0;
      wb_err    = 1'b0;
      if (arb_any) begin
         wb_valid = 1'b1;
         wb_tag   = arb_idx;
         wb_rd    = rd_q[arb_idx];
         wb_data  = data_q[arb_idx];
         wb_err   = err_q[arb_idx];
      end else if (byp) begin
         wb_valid = 1'b1;
         wb_tag   = ret_tag;
         wb_rd    = rd_q[ret_tag];
         wb_data  = ret_data;
         wb_err   = ret_err;
      end
      cam_hit1 = 1'b0;
      cam_hit2 = 1'b0;
      for (int i = 0; i < NUM_TAGS; i++) begin
         if (live[i] && rd_q[i] == cam_rs1) cam_hit1 = 1'b1;
         if (live[i] && rd_q[i] == cam_rs2) cam_hit2 = 1'b1;
      end
      if (cam_rs1 == 5'd0) cam_hit1 = 1'b0;
      if (cam_rs2 == 5'd0) cam_hit2 = 1'b0;
   end

endmodule

// File: tb/tb_lsu_nbload_sched.sv
// tb_lsu_nbload_sched: directed vector bench for lsu_nbload_sched.
// Inputs change on negedge, outputs sampled 1ns later.
module tb_lsu_nbload_sched;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        alloc_req;
   logic [4:0]  alloc_rd;
   logic        alloc_gnt;
   logic [1:0]  alloc_tag;
   logic        ret_valid;
   logic [1:0]  ret_tag;
   logic [31:0] ret_data;
   logic        ret_err;
   logic        flush;
   logic [4:0]  cam_rs1, cam_rs2;
   logic        cam_hit1, cam_hit2;
   logic        wb_ready;
   logic        wb_valid;
   logic [1:0]  wb_tag;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_err;
   logic        full, empty, ret_unexp;

   always #5 clk = ~clk;

   lsu_nbload_sched #(.NUM_TAGS(4), .TAG_W(2)) dut (
      .clk(clk), .rst_l(rst_l),
      .alloc_req(alloc_req), .alloc_rd(alloc_rd),
      .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
      .ret_valid(ret_valid), .ret_tag(ret_tag),
      .ret_data(ret_data), .ret_err(ret_err),
      .flush(flush),
      .cam_rs1(cam_rs1), .cam_rs2(cam_rs2),
      .cam_hit1(cam_hit1), .cam_hit2(cam_hit2),
      .wb_ready(wb_ready), .wb_valid(wb_valid),
      .wb_tag(wb_tag), .wb_rd(wb_rd),
      .wb_data(wb_data), .wb_err(wb_err),
      .full(full), .empty(empty), .ret_unexp(ret_unexp)
   );

   typedef struct {
      logic        areq;
      logic [4:0]  ard;
      logic        rv;
      logic [1:0]  rt;
      logic [31:0] rdat;
      logic        rerr;
      logic        fl;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        wrdy;
      logic        gnt;
      logic [1:0]  atag;
      logic        wv;
      logic [1:0]  wt;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic        we;
      logic        full;
      logic        empty;
      logic        unexp;
      logic        h1;
      logic        h2;
   } vec_t;

   vec_t tbl [64];
   int   nv = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic r(
      input logic areq, input logic [4:0] ard,
      input logic rv, input logic [1:0] rt,
      input logic [31:0] rdat, input logic rerr,
      input logic fl, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic wrdy,
      input logic gnt, input logic [1:0] atag,
      input logic wv, input logic [1:0] wt,
      input logic [4:0] wrd, input logic [31:0] wd,
      input logic we, input logic f, input logic e,
      input logic u, input logic h1, input logic h2);
      vec_t v;
      v.areq = areq; v.ard = ard; v.rv = rv; v.rt = rt;
      v.rdat = rdat; v.rerr = rerr; v.fl = fl;
      v.rs1 = rs1; v.rs2 = rs2; v.wrdy = wrdy;
      v.gnt = gnt; v.atag = atag; v.wv = wv; v.wt = wt;
      v.wrd = wrd; v.wd = wd; v.we = we; v.full = f;
      v.empty = e; v.unexp = u; v.h1 = h1; v.h2 = h2;
      tbl[nv] = v;
      nv++;
   endtask

   function automatic logic [63:0] act_of();
      return 64'({alloc_gnt, alloc_tag, wb_valid, wb_tag,
                  wb_rd, wb_data, wb_err, full, empty,
                  ret_unexp, cam_hit1, cam_hit2});
   endfunction

   function automatic logic [63:0] exp_of(input vec_t v);
      return 64'({v.gnt, v.atag, v.wv, v.wt, v.wrd, v.wd,
                  v.we, v.full, v.empty, v.unexp, v.h1, v.h2});
   endfunction

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      alloc_req = v.areq; alloc_rd = v.ard;
      ret_valid = v.rv; ret_tag = v.rt;
      ret_data = v.rdat; ret_err = v.rerr;
      flush = v.fl; cam_rs1 = v.rs1; cam_rs2 = v.rs2;
      wb_ready = v.wrdy;
   endtask

   task automatic idle_in();
      alloc_req = 0; alloc_rd = 0; ret_valid = 0;
      ret_tag = 0; ret_data = 0; ret_err = 0; flush = 0;
      cam_rs1 = 0; cam_rs2 = 0; wb_ready = 0;
   endtask

   initial begin
      rst_l = 1'b0;
      idle_in();

      // alloc 5..8, full, refused 5th
      r(1,5, 0,0,0,0, 0, 5,0, 0, 1,0, 0,0,0,0,0, 0,1,0, 0,0);
      r(1,6, 0,0,0,0, 0, 5,6, 0, 1,1, 0,0,0,0,0, 0,0,0, 1,0);
      r(1,7, 0,0,0,0, 0, 6,7, 0, 1,2, 0,0,0,0,0, 0,0,0, 1,0);
      r(1,8, 0,0,0,0, 0, 7,8, 0, 1,3, 0,0,0,0,0, 0,0,0, 1,0);
      r(1,9, 0,0,0,0, 0, 8,0, 0, 0,0, 0,0,0,0,0, 1,0,0, 1,0);
      // out-of-order returns 2,0,1,3 then drain
      r(0,0, 1,2,32'h702,0, 0, 0,0, 0, 0,0, 0,0,0,0,0, 1,0,0, 0,0);
      r(0,0, 1,0,32'h500,0, 0, 0,0, 1, 0,0, 1,2,7,32'h702,0, 1,0,0, 0,0);
      r(0,0, 1,1,32'h600,1, 0, 0,0, 1, 0,2, 1,0,5,32'h500,0, 0,0,0, 0,0);
      r(0,0, 1,3,32'h800,0, 0, 0,0, 1, 0,0, 1,1,6,32'h600,1, 0,0,0, 0,0);
      r(0,0, 0,0,0,0, 0, 0,0, 1, 0,0, 1,3,8,32'h800,0, 0,0,0, 0,0);
      r(0,0, 0,0,0,0, 0, 0,0, 1, 0,0, 0,0,0,0,0, 0,1,0, 0,0);
      // same-rd supersede
      r(1,5, 0,0,0,0, 0, 5,0, 0, 1,0, 0,0,0,0,0, 0,1,0, 0,0);
      r(1,5, 0,0,0,0, 0, 5,0, 0, 1,1, 0,0,0,0,0, 0,0,0, 1,0);
      r(0,0, 1,0,32'h1111,0, 0, 5,0, 1, 0,2, 0,0,0,0,0, 0,0,0, 1,0);
      r(0,0, 0,0,0,0, 0, 5,0, 1, 0,2, 0,0,0,0,0, 0,0,0, 1,0);
      r(0,0, 1,1,32'h5555,0, 0, 5,0, 0, 0,0, 0,0,0,0,0, 0,0,0, 1,0);
      r(0,0, 0,0,0,0, 0, 5,0, 1, 0,0, 1,1,5,32'h5555,0, 0,0,0, 1,0);
      r(0,0, 0,0,0,0, 0, 5,0, 1, 0,0, 0,0,0,0,0, 0,1,0, 0,0);
      // flush -> discard, unexpected return
      r(1,10, 0,0,0,0, 0, 0,0, 0, 1,0, 0,0,0,0,0, 0,1,0, 0,0);
      r(1,11, 0,0,0,0, 0, 0,0, 0, 1,1, 0,0,0,0,0, 0,0,0, 0,0);
      r(0,0, 0,0,0,0, 1, 10,11, 0, 0,2, 0,0,0,0,0, 0,0,0, 1,1);
      r(0,0, 1,0,0,0, 0, 10,11, 1, 0,2, 0,0,0,0,0, 0,0,0, 0,0);
      r(0,0, 1,1,0,0, 0, 0,0, 1, 0,0, 0,0,0,0,0, 0,0,0, 0,0);
      r(0,0, 1,2,0,0, 0, 0,0, 1, 0,0, 0,0,0,0,0, 0,1,1, 0,0);
      r(0,0, 0,0,0,0, 0, 0,0, 1, 0,0, 0,0,0,0,0, 0,1,0, 0,0);
      // alloc+flush+ret same cycle, stall hold, rr
      r(1,12, 0,0,0,0, 0, 0,0, 0, 1,0, 0,0,0,0,0, 0,1,0, 0,0);
      r(1,13, 0,0,0,0, 0, 0,0, 0, 1,1, 0,0,0,0,0, 0,0,0, 0,0);
      r(1,14, 1,0,32'hC0,0, 1, 13,14, 0, 1,2, 0,0,0,0,0, 0,0,0, 1,0);
      r(0,0, 1,2,32'hE0,0, 0, 13,14, 0, 0,3, 1,0,12,32'hC0,0, 0,0,0, 0,1);
      r(0,0, 0,0,0,0, 0, 0,0, 0, 0,3, 1,0,12,32'hC0,0, 0,0,0, 0,0);
      r(0,0, 0,0,0,0, 0, 0,0, 0, 0,3, 1,0,12,32'hC0,0, 0,0,0, 0,0);
      r(0,0, 0,0,0,0, 0, 0,0, 1, 0,3, 1,0,12,32'hC0,0, 0,0,0, 0,0);
      r(0,0, 0,0,0,0, 0, 0,0, 1, 0,0, 1,2,14,32'hE0,0, 0,0,0, 0,0);
      r(0,0, 1,1,0,0, 0, 0,0, 1, 0,0, 0,0,0,0,0, 0,0,0, 0,0);
      r(0,0, 0,0,0,0, 0, 0,0, 1, 0,0, 0,0,0,0,0, 0,1,0, 0,0);

      repeat (2) @(negedge clk);
      #1;
      chk("rst_outs", act_of(), 64'h8);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);

      @(negedge clk);
      rst_l = 1'b1;

      for (int i = 0; i < nv; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("row%0d", i), act_of(), exp_of(tbl[i]));
      end

      // return-to-writeback latency
      @(negedge clk);
      idle_in();
      alloc_req = 1; alloc_rd = 9;
      #1;
      chk("lat_gnt", 64'({alloc_gnt, alloc_tag}), 64'h4);
      @(negedge clk);
      idle_in();
      ret_valid = 1; ret_tag = 0;
      ret_data = 32'hA5A5_0001; wb_ready = 1;
      #1;
`ifdef LSU_NBLOAD_WB_BYPASS_EN
      chk("lat_c0_valid", 64'(wb_valid), 64'd1);
      chk("lat_c0_pkt", 64'({wb_tag, wb_rd, wb_data}),
          64'({2'd0, 5'd9, 32'hA5A5_0001}));
`else
      chk("lat_c0_valid", 64'(wb_valid), 64'd0);
`endif
      @(negedge clk);
      ret_valid = 0; ret_data = 0;
      #1;
`ifdef LSU_NBLOAD_WB_BYPASS_EN
      chk("lat_c1_valid", 64'(wb_valid), 64'd0);
      chk("lat_c1_empty", 64'(empty), 64'd1);
`else
      chk("lat_c1_valid", 64'(wb_valid), 64'd1);
      chk("lat_c1_pkt", 64'({wb_tag, wb_rd, wb_data}),
          64'({2'd0, 5'd9, 32'hA5A5_0001}));
`endif
      @(negedge clk);
      #1;
      chk("lat_end", 64'({wb_valid, empty}), 64'b01);

      // asynchronous reset mid-cycle
      @(negedge clk);
      idle_in();
      alloc_req = 1; alloc_rd = 3; cam_rs1 = 3;
      @(negedge clk);
      alloc_req = 0;
      #1;
      chk("arst_pre", 64'({empty, cam_hit1}), 64'b01);
      #2;
      rst_l = 1'b0;
      #1;
      chk("arst_post", 64'({empty, cam_hit1, full}), 64'b100);
      @(negedge clk);
      rst_l = 1'b1;
      idle_in();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
